mem_access_ctrl: RTL and testbench

Multicycle memory access controller between the CPU control unit and the word-wide data memory. It accepts one load/store request at a time and places byte and halfword data in the correct lanes of the 32-bit memory word. Sub-word stores run as read-modify-write; loads return extracted, zero-extended data. It is the memory-facing counterpart of the datapath size-handling mux: it drives the memory port and sequences the accesses.

---
 rtl/mem_access_ctrl_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, memory and response signals of the memory
// access controller, bundled so the controller and its environment share one
// port.
//   req_valid/req_ready/req_op/req_addr/req_wdata : request handshake + fields
//   mem_addr/mem_wr/mem_wdata/mem_rdata           : word-wide data memory port
//   rsp_valid/rsp_rdata/rsp_err                   : one-cycle completion
// master: requester / memory side.  slave: the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle load/store sequencer in front of a word-wide
// data memory. One request at a time; byte/halfword stores are done as
// read-modify-write, loads return the selected lane zero-extended.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mem_access_ctrl_if.slave (request, memory port, response)
//   MEM_LAT  : memory read latency in cycles, 1..4
//
//   state    | meaning
//   ST_IDLE  | ready for a request, memory port idle
//   ST_READ  | word read in flight, MEM_LAT cycles
//   ST_WRITE | single-cycle write strobe
//   ST_RESP  | one-cycle completion pulse
module mem_access_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SW = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_LB = 3'b011;
  localparam logic [2:0] OP_LW = 3'b100;
  localparam logic [2:0] OP_LH = 3'b101;

  localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  cnt;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        accept;
  logic        req_misaligned;
  logic        req_err;
  logic        read_done;
  logic        sub_store_q;

  assign accept      = bus.req_valid && (state == ST_IDLE);
  assign read_done   = (state == ST_READ) && (cnt == 2'd0);
  assign sub_store_q = (op_q == OP_SB) || (op_q == OP_SH);

  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_op)
      OP_SH, OP_LH: req_misaligned = bus.req_addr[0];
      OP_SW, OP_LW: req_misaligned = |bus.req_addr[1:0];
      default:      req_misaligned = 1'b0;
    endcase
  end

  // 110/111 are the only illegal encodings
  assign req_err = (bus.req_op[2] & bus.req_op[1]) | req_misaligned;

  // Insert the store byte/halfword into its lane, keeping the other lanes.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [2:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (op == OP_SB) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [2:0]  op,
                                               input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (op == OP_LB) begin
      case (lane)
        2'd0:    r = {24'd0, word[7:0]};
        2'd1:    r = {24'd0, word[15:8]};
        2'd2:    r = {24'd0, word[23:16]};
        default: r = {24'd0, word[31:24]};
      endcase
    end else if (op == OP_LH) begin
      r = lane[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                   state_nxt = ST_RESP;
          else if (bus.req_op == OP_SW)  state_nxt = ST_WRITE;
          else                           state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (cnt == 2'd0) state_nxt = sub_store_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so a reset drops them immediately.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_IDLE:  bus.req_ready = 1'b1;
      ST_WRITE: bus.mem_wr    = 1'b1;
      ST_RESP:  bus.rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Read-latency timer; reaching zero marks the capture edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 2'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == ST_READ) && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 16'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      op_q        <= bus.req_op;
      lane_q      <= bus.req_addr[1:0];
      wdata_q     <= bus.req_wdata[15:0];
      mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= req_err;
      if (!req_err && (bus.req_op == OP_SW)) mem_wdata_q <= bus.req_wdata;
    end else if (read_done) begin
      if (sub_store_q) mem_wdata_q <= merge_lane(bus.mem_rdata, op_q, lane_q, wdata_q);
      else             rsp_rdata_q <= extract_lane(bus.mem_rdata, op_q, lane_q);
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with MEM_LAT=1 and one with
// MEM_LAT=3. Requests are issued by a single stimulus process that predicts
// each write and response from the load/store rules and queues them; a
// negedge monitor pops and compares whatever the controllers present.
module tb_mem_access_ctrl;

  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SW = 3'b001;
  localparam logic [2:0] OP_SH = 3'b010;
  localparam logic [2:0] OP_LB = 3'b011;
  localparam logic [2:0] OP_LW = 3'b100;
  localparam logic [2:0] OP_LH = 3'b101;

  typedef struct {
    int          at;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          at;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  int          cyc = 0;
  logic [1:0]  rv;
  logic [2:0]  rop [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  logic [1:0]  rdy, wr, rvld, rerr;
  logic [31:0] ma [2];
  logic [31:0] mwd [2];
  logic [31:0] rrd [2];
  logic [31:0] env0 [256];
  logic [31:0] env1 [256];
  logic [31:0] ref_mem [2][256];
  int          age [2];
  int          busy_until [2];
  wr_t         wq [2][$];
  rsp_t        rq [2][$];
  int          checks = 0;
  int          errors = 0;
  int          timeouts = 0;
  bit          done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if bus_l1 ();
  mem_access_ctrl_if bus_l3 ();

  mem_access_ctrl #(.MEM_LAT(1)) u_dut_l1 (.clk(clk), .reset_n(rst_n[0]), .bus(bus_l1));
  mem_access_ctrl #(.MEM_LAT(3)) u_dut_l3 (.clk(clk), .reset_n(rst_n[1]), .bus(bus_l3));

  assign bus_l1.req_valid = rv[0];
  assign bus_l1.req_op    = rop[0];
  assign bus_l1.req_addr  = raddr[0];
  assign bus_l1.req_wdata = rwd[0];
  assign bus_l3.req_valid = rv[1];
  assign bus_l3.req_op    = rop[1];
  assign bus_l3.req_addr  = raddr[1];
  assign bus_l3.req_wdata = rwd[1];

  assign rdy[0] = bus_l1.req_ready;  assign rdy[1] = bus_l3.req_ready;
  assign wr[0]  = bus_l1.mem_wr;     assign wr[1]  = bus_l3.mem_wr;
  assign rvld[0] = bus_l1.rsp_valid; assign rvld[1] = bus_l3.rsp_valid;
  assign rerr[0] = bus_l1.rsp_err;   assign rerr[1] = bus_l3.rsp_err;
  assign ma[0]  = bus_l1.mem_addr;   assign ma[1]  = bus_l3.mem_addr;
  assign mwd[0] = bus_l1.mem_wdata;  assign mwd[1] = bus_l3.mem_wdata;
  assign rrd[0] = bus_l1.rsp_rdata;  assign rrd[1] = bus_l3.rsp_rdata;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A17C3E9;
  endfunction

  // Memory: data is only correct once the address has been up for MEM_LAT
  // cycles; before that the inverted word is returned.
  assign bus_l1.mem_rdata = env0[ma[0][9:2]];
  assign bus_l3.mem_rdata = (age[1] >= 2) ? env1[ma[1][9:2]] : ~env1[ma[1][9:2]];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) begin
        env0[i] <= init_word(i);
        env1[i] <= init_word(i);
      end
    end else begin
      if (wr[0]) env0[ma[0][9:2]] <= mwd[0];
      if (wr[1]) env1[ma[1][9:2]] <= mwd[1];
    end
    for (int g = 0; g < 2; g++) begin
      if (rv[g] && rdy[g]) age[g] <= 0;
      else if (age[g] < 15) age[g] <= age[g] + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic string nm(input int g, input string s);
    return $sformatf("lat%0d_%s", (g == 0) ? 1 : 3, s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_one(input int g);
    wr_t  w;
    rsp_t r;
    if (!rst_n[g]) begin
      check(nm(g, "rst_req_ready"), 32'(rdy[g]), 32'd1);
      check(nm(g, "rst_strobes"), {29'd0, wr[g], rvld[g], rerr[g]}, 32'd0);
      check(nm(g, "rst_mem_addr"), ma[g], 32'd0);
      check(nm(g, "rst_mem_wdata"), mwd[g], 32'd0);
      check(nm(g, "rst_rsp_rdata"), rrd[g], 32'd0);
    end else begin
      check(nm(g, "req_ready"), 32'(rdy[g]), 32'(cyc > busy_until[g]));
      while (wq[g].size() > 0 && wq[g][0].at < cyc) begin
        w = wq[g].pop_front();
        check(nm(g, "wr_missing_at_cycle"), 32'(cyc), 32'(w.at));
      end
      while (rq[g].size() > 0 && rq[g][0].at < cyc) begin
        r = rq[g].pop_front();
        check(nm(g, "rsp_missing_at_cycle"), 32'(cyc), 32'(r.at));
      end
      if (wr[g]) begin
        if (wq[g].size() == 0) begin
          check(nm(g, "wr_unexpected"), 32'd1, 32'd0);
        end else begin
          w = wq[g].pop_front();
          check(nm(g, "wr_cycle"), 32'(cyc), 32'(w.at));
          check(nm(g, "wr_addr"), ma[g], w.a);
          check(nm(g, "wr_data"), mwd[g], w.d);
        end
      end
      if (rvld[g]) begin
        if (rq[g].size() == 0) begin
          check(nm(g, "rsp_unexpected"), 32'd1, 32'd0);
        end else begin
          r = rq[g].pop_front();
          check(nm(g, "rsp_cycle"), 32'(cyc), 32'(r.at));
          check(nm(g, "rsp_rdata"), rrd[g], r.d);
          check(nm(g, "rsp_err"), 32'(rerr[g]), 32'(r.e));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0);
    mon_one(1);
    if (done || cyc > 40000) begin
      if (!done) check("watchdog_stimulus_done", 32'd0, 32'd1);
      for (int g = 0; g < 2; g++) begin
        check(nm(g, "writes_left"), 32'(wq[g].size()), 32'd0);
        check(nm(g, "rsps_left"), 32'(rq[g].size()), 32'd0);
      end
      check("issue_timeouts", 32'(timeouts), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic predict(input int g, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int c);
    int          lat, bs, hs;
    bit          err;
    logic [31:0] word, nw;
    wr_t         w;
    rsp_t        r;
    lat  = (g == 0) ? 1 : 3;
    word = ref_mem[g][addr[9:2]];
    bs   = 8 * int'(addr[1:0]);
    hs   = 16 * int'(addr[1]);
    err  = (op > 3'd5)
        || (((op == OP_SH) || (op == OP_LH)) && addr[0])
        || (((op == OP_SW) || (op == OP_LW)) && (addr[1:0] != 2'b00));
    w.a = addr & 32'hFFFF_FFFC;
    r.d = 32'd0;
    r.e = 1'b0;
    if (err) begin
      r.at = c + 1;
      r.e  = 1'b1;
    end else if (op == OP_SW || op == OP_SB || op == OP_SH) begin
      if (op == OP_SW)      nw = wd;
      else if (op == OP_SB) nw = (word & ~(32'hFF << bs)) | ((wd & 32'hFF) << bs);
      else                  nw = (word & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
      w.at = (op == OP_SW) ? c + 1 : c + lat + 1;
      w.d  = nw;
      wq[g].push_back(w);
      ref_mem[g][addr[9:2]] = nw;
      r.at = w.at + 1;
    end else begin
      if (op == OP_LW)      r.d = word;
      else if (op == OP_LH) r.d = (word >> hs) & 32'hFFFF;
      else                  r.d = (word >> bs) & 32'hFF;
      r.at = c + lat + 1;
    end
    rq[g].push_back(r);
    busy_until[g] = r.at;
  endtask

  // Presents a request and waits for its accept cycle c. With keep=1 valid
  // stays high afterwards carrying junk fields while the controller is busy.
  task automatic issue(input int g, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input bit keep, input bit track, output int c);
    bit got;
    got = 1'b0;
    c = 0;
    rop[g] = op; raddr[g] = addr; rwd[g] = wd; rv[g] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (rdy[g]) begin
        got = 1'b1;
        c = cyc;
      end
    end
    if (!got) begin
      timeouts++;
      $display("FAIL %s: req_ready 0 for 50 cycles, expected 1", nm(g, "issue_timeout"));
      rv[g] = 1'b0;
    end else begin
      if (track) predict(g, op, addr, wd, c);
      else       busy_until[g] = c + 2;
      @(posedge clk); #1;
      rv[g]    = keep;
      rop[g]   = 3'($urandom);
      raddr[g] = $urandom;
      rwd[g]   = $urandom;
    end
  endtask

  initial begin
    int          c;
    logic [2:0]  op;
    logic [31:0] addr;
    rst_n = 2'b00;
    rv    = 2'b00;
    for (int g = 0; g < 2; g++) begin
      rop[g] = 3'd0; raddr[g] = 32'd0; rwd[g] = 32'd0;
      busy_until[g] = -1;
      for (int i = 0; i < 256; i++) ref_mem[g][i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 2'b11;
    @(posedge clk); #1;

    // MEM_LAT = 1: byte store RMW, loads, errors, held valid, address wrap
    issue(0, OP_SW, 32'h0000_0100, 32'h1122_3344, 1'b0, 1'b1, c);
    issue(0, OP_SB, 32'h0000_0102, 32'h0000_00AB, 1'b0, 1'b1, c);
    issue(0, OP_LW, 32'h0000_0100, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_SW, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 1'b1, c);
    issue(0, OP_LH, 32'h0000_0202, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_LB, 32'h0000_0203, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_LB, 32'h0000_0200, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_LW, 32'h0000_0200, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_LW, 32'h0000_0201, 32'h0,         1'b0, 1'b1, c);
    issue(0, OP_SH, 32'h0000_0203, 32'h0000_5555, 1'b0, 1'b1, c);
    issue(0, 3'b110, 32'h0000_0200, 32'h0,        1'b0, 1'b1, c);
    issue(0, OP_SW, 32'h0000_0300, 32'hCAFE_F00D, 1'b1, 1'b1, c);
    issue(0, OP_SW, 32'h0000_0304, 32'h1357_9BDF, 1'b1, 1'b1, c);
    issue(0, OP_LW, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b1, c);
    for (int n = 0; n < 150; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
      issue(0, op, addr, $urandom, 1'($urandom_range(0, 1)), 1'b1, c);
    end
    rv[0] = 1'b0;

    // MEM_LAT = 3: halfword RMW, reset abort mid-read, recovery, random
    issue(1, OP_SW, 32'h0000_0400, 32'hAAAA_BBBB, 1'b0, 1'b1, c);
    issue(1, OP_SH, 32'h0000_0402, 32'h0000_1234, 1'b0, 1'b1, c);
    issue(1, OP_SB, 32'h0000_0501, 32'h0000_0077, 1'b0, 1'b0, c);
    @(posedge clk); #2 rst_n[1] = 1'b0;
    @(posedge clk); #2 rst_n[1] = 1'b1;
    issue(1, OP_LW, 32'h0000_0400, 32'h0,         1'b0, 1'b1, c);
    issue(1, OP_LW, 32'h0000_0500, 32'h0,         1'b0, 1'b1, c);
    for (int n = 0; n < 60; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'h0000_03FF;
      issue(1, op, addr, $urandom, 1'($urandom_range(0, 1)), 1'b1, c);
    end
    rv[1] = 1'b0;

    repeat (10) @(posedge clk);
    done = 1'b1;
  end

endmodule
